int_sqrt: RTL and testbench
===========================

INT_SQRT -- requirements
Module: int_sqrt

Interface
REQ-001 SHALL have parameter D_W, default 32, radicand width; only 32 is supported (lopd is hardcoded for 32 bits).
REQ-002 SHALL have parameter Q_W, default D_W/2, root width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, radicand valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a radicand.
REQ-007 SHALL have port in_data, input, D_W, unsigned radicand x.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port out_data, output, Q_W, unsigned q = floor(sqrt(x)).
REQ-011 SHALL have port out_rem, output, Q_W+1, unsigned remainder r = x - q*q, with 0 <= r <= 2q.

Function
REQ-012 SHALL use a state machine with states IDLE, INIT, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are decoded from registered state.
REQ-014 Acceptance SHALL occur in cycle N when in_valid and in_ready are both 1; x is registered and the state moves to INIT.
REQ-015 In INIT, the block SHALL instantiate lopd on the registered x and set pair index k = lopd_out >> 1.
REQ-016 In INIT, q and the internal remainder (Q_W+2 bits) SHALL be cleared to 0.
REQ-017 In INIT, the iteration counter SHALL be loaded with k.
REQ-018 In INIT, the next state SHALL be CALC if x != 0, and DONE with q=0, r=0 if x == 0.
REQ-019 Each CALC cycle i = counter SHALL compute t = (rem << 2) | x[2i+1:2i] and trial = (q << 2) | 1.
REQ-020 If t >= trial, then rem <= t - trial and q <= (q << 1) | 1; otherwise rem <= t and q <= q << 1.
REQ-021 CALC SHALL go to DONE when the counter is 0, else decrement the counter; it runs exactly k+1 cycles.
REQ-022 Latency SHALL be: out_valid first 1 in cycle N+k+3 for x != 0, and in cycle N+2 for x == 0; the maximum is N+18 (x >= 2^30).
REQ-023 In DONE, out_valid, out_data and out_rem SHALL be held stable until out_ready is 1; that cycle completes the transfer and the next state is IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE.
REQ-025 No new radicand SHALL be accepted in the same cycle as an output handshake.
REQ-026 Minimum spacing between acceptances SHALL be k+4 cycles.
REQ-027 in_data SHALL NOT be sampled after acceptance; changes to in_data during INIT, CALC or DONE SHALL NOT affect the result.
REQ-028 out_data and out_rem SHALL retain the last result after the DONE->IDLE transfer until the next INIT.
REQ-029 out_valid SHALL NOT depend combinationally on out_ready.
REQ-030 in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-031 While rst_n = 0, regardless of clk: state = IDLE, out_valid = 0, out_data = 0, out_rem = 0, counter = 0, internal rem/q/x = 0, in_ready = 1.
REQ-032 No transfer SHALL be recognised while rst_n = 0.
REQ-033 Reset asserted during INIT, CALC or DONE SHALL abort the operation and produce no out_valid pulse.
REQ-034 The first acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Verification
REQ-035 Zero: x=0 accepted in cycle N -> out_valid in N+2, out_data=0, out_rem=0.
REQ-036 Small operands:
- x=1 -> out_valid in N+3, q=1, r=0.
- x=2 -> out_valid in N+3, q=1, r=1.
- x=16 -> out_valid in N+5, q=4, r=0.
- x=24 -> out_valid in N+5, q=4, r=8.
REQ-037 Maximum: x=0xFFFFFFFF -> out_valid in N+18, q=65535, r=131070.
- x=0x40000000 -> out_valid in N+18, q=32768, r=0.
REQ-038 Backpressure: x=24 with out_ready=0 for 10 cycles -> out_valid, q=4, r=8 held stable all 10 cycles; in_ready=0 throughout even with in_valid=1.
- out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-039 Reset mid-op: x=0xFFFFFFFF accepted, rst_n=0 asynchronously in N+6 -> out_valid=0, in_ready=1 immediately.
- After release, x=9 -> q=3, r=0 in N'+4; no stale result appears.
REQ-040 Random: 10k random x with random in_valid/out_ready -> r = x - q*q, 0 <= r <= 2q, latency per REQ-022, no lost or duplicated transfers.

Source files
------------

// File: rtl/int_sqrt.sv
// Sequential integer square root: floor(sqrt(x)) and remainder, one result bit per cycle.
// Iterations start at the leading radicand bit pair, so small operands finish early.

module lopd (
    input  logic [31:0] in_data,
    output logic [4:0]  pos
);

    // Position of the most significant set bit (0 when the input is zero)
    always_comb begin
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            pos = in_data[i] ? 5'(i) : pos;
        end
    end

endmodule

module int_sqrt #(
    parameter int D_W = 32,
    parameter int Q_W = D_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   out_data,
    output logic [Q_W:0]     out_rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [D_W-1:0]  x_r;
    logic [Q_W-1:0]  q_r;
    logic [Q_W+1:0]  rem_r;
    logic [4:0]      cnt_r;
    logic [4:0]      lopd_s;
    logic [1:0]      pair_s;
    logic [Q_W+1:0]  t_s;
    logic [Q_W+1:0]  trial_s;
    logic            fits_s;

    lopd u_lopd (
        .in_data (x_r),
        .pos     (lopd_s)
    );

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign out_data  = q_r;
    assign out_rem   = rem_r[Q_W:0];

    // One restoring step: bring down the next radicand bit pair and try to subtract
    always_comb begin
        pair_s  = x_r[{cnt_r, 1'b0} +: 2];
        t_s     = (rem_r << 2) | {{Q_W{1'b0}}, pair_s};
        trial_s = {q_r, 2'b01};
        fits_s  = (t_s >= trial_s);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = INIT;
                end else begin
                    state_s = IDLE;
                end
            end
            INIT: begin
                if (x_r != {D_W{1'b0}}) begin
                    state_s = CALC;
                end else begin
                    state_s = DONE;
                end
            end
            CALC: begin
                if (cnt_r == 5'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: capture radicand, clear/load in INIT, iterate in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= {D_W{1'b0}};
            q_r   <= {Q_W{1'b0}};
            rem_r <= {(Q_W+2){1'b0}};
            cnt_r <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r <= in_data;
                    end
                end
                INIT: begin
                    q_r   <= {Q_W{1'b0}};
                    rem_r <= {(Q_W+2){1'b0}};
                    cnt_r <= lopd_s >> 1;
                end
                CALC: begin
                    if (fits_s) begin
                        rem_r <= t_s - trial_s;
                        q_r   <= {q_r[Q_W-2:0], 1'b1};
                    end else begin
                        rem_r <= t_s;
                        q_r   <= {q_r[Q_W-2:0], 1'b0};
                    end
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_sqrt.sv
// Directed and randomised checks of int_sqrt: results, latency, backpressure and reset abort.
`timescale 1ns/1ps

module tb_int_sqrt;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [16:0] out_rem;

    int total;
    int bad;
    int hs_cnt;
    int ops_cnt;

    int_sqrt #(.D_W(32), .Q_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rem   (out_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts completed output transfers
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    // Called at a negedge with the DUT idle; returns negedges waited for acceptance and latency
    task automatic start_op(input logic [31:0] x, output int wait_n, output int lat);
        wait_n = 0;
        in_valid = 1'b1;
        in_data = x;
        while (!in_ready && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            in_data = $urandom;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ops_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h0000_FFFF;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        total++;
        if (out_data !== 16'd0 || out_rem !== 17'd0) begin
            bad++;
            $display("FAIL reset_data q=%0d r=%0d required 0/0", out_data, out_rem);
        end
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_held in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_zero();
        int w, lat;
        start_op(32'd0, w, lat);
        total++;
        if (w !== 0) begin
            bad++;
            $display("FAIL first_accept waited=%0d required 0", w);
        end
        total++;
        if (lat !== 2 || out_data !== 16'd0 || out_rem !== 17'd0) begin
            bad++;
            $display("FAIL zero lat=%0d q=%0d r=%0d required 2/0/0", lat, out_data, out_rem);
        end
        finish_op();
    endtask

    task automatic test_small();
        logic [31:0] xs [7];
        logic [15:0] qs [7];
        logic [16:0] rs [7];
        int          ls [7];
        int w, lat;
        xs = '{32'd1, 32'd2, 32'd3, 32'd16, 32'd24, 32'd255, 32'd256};
        qs = '{16'd1, 16'd1, 16'd1, 16'd4, 16'd4, 16'd15, 16'd16};
        rs = '{17'd0, 17'd1, 17'd2, 17'd0, 17'd8, 17'd30, 17'd0};
        ls = '{3, 3, 3, 5, 5, 6, 7};
        for (int i = 0; i < 7; i++) begin
            start_op(xs[i], w, lat);
            total++;
            if (out_data !== qs[i] || out_rem !== rs[i] || lat !== ls[i]) begin
                bad++;
                $display("FAIL small x=%0d q=%0d r=%0d lat=%0d required %0d/%0d/%0d",
                         xs[i], out_data, out_rem, lat, qs[i], rs[i], ls[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_max();
        logic [31:0] xs [3];
        logic [15:0] qs [3];
        logic [16:0] rs [3];
        int          ls [3];
        int w, lat;
        xs = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF};
        qs = '{16'd65535, 16'd32768, 16'd32767};
        rs = '{17'd131070, 17'd0, 17'd65534};
        ls = '{18, 18, 17};
        for (int i = 0; i < 3; i++) begin
            start_op(xs[i], w, lat);
            total++;
            if (out_data !== qs[i] || out_rem !== rs[i] || lat !== ls[i]) begin
                bad++;
                $display("FAIL max x=%h q=%0d r=%0d lat=%0d required %0d/%0d/%0d",
                         xs[i], out_data, out_rem, lat, qs[i], rs[i], ls[i]);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int w, lat;
        start_op(32'd24, w, lat);
        total++;
        if (lat !== 5) begin
            bad++;
            $display("FAIL bp_latency lat=%0d required 5", lat);
        end
        in_valid = 1'b1;
        in_data = 32'd99;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'd4 || out_rem !== 17'd8 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d v=%b q=%0d r=%0d rdy=%b required 1/4/8/0",
                         c, out_valid, out_data, out_rem, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_op();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'd4 || out_rem !== 17'd8) begin
            bad++;
            $display("FAIL bp_release rdy=%b v=%b q=%0d r=%0d required 1/0/4/8",
                     in_ready, out_valid, out_data, out_rem);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1;
        second = -1;
        in_valid = 1'b1;
        in_data = 32'd16;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                total++;
                if (out_data !== 16'd4 || out_rem !== 17'd0 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_result q=%0d r=%0d rdy=%b required 4/0/0", out_data, out_rem, in_ready);
                end
            end
            if (in_ready) begin
                if (first < 0) begin
                    first = c;
                end else begin
                    second = c;
                    break;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        ops_cnt++;
        total++;
        if (second - first !== 6) begin
            bad++;
            $display("FAIL b2b_spacing spacing=%0d required 6", second - first);
        end
    endtask

    task automatic test_reset_midop();
        int w, lat, hs_before;
        hs_before = hs_cnt;
        in_valid = 1'b1;
        in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'd0 || out_rem !== 17'd0) begin
            bad++;
            $display("FAIL midop_reset v=%b rdy=%b q=%0d r=%0d required 0/1/0/0",
                     out_valid, in_ready, out_data, out_rem);
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midop_held v=%b required 0", out_valid);
        end
        rst_n = 1'b1;
        start_op(32'd9, w, lat);
        total++;
        if (w !== 0 || lat !== 4 || out_data !== 16'd3 || out_rem !== 17'd0) begin
            bad++;
            $display("FAIL midop_after wait=%0d lat=%0d q=%0d r=%0d required 0/4/3/0",
                     w, lat, out_data, out_rem);
        end
        total++;
        if (hs_cnt !== hs_before) begin
            bad++;
            $display("FAIL midop_stale handshakes=%0d required %0d", hs_cnt, hs_before);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [31:0] x;
        longint      lo, hi, mid, eq, er;
        int          w, lat, el, msb, hold;
        logic [15:0] q0;
        logic [16:0] r0;
        for (int n = 0; n < 300; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            lo = 0;
            hi = 65536;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (mid * mid <= longint'(x)) lo = mid;
                else hi = mid;
            end
            eq = lo;
            er = longint'(x) - eq * eq;
            msb = 0;
            for (int b = 0; b < 32; b++) if (x[b]) msb = b;
            el = (x == 32'd0) ? 2 : (msb / 2) + 3;
            start_op(x, w, lat);
            total++;
            if (longint'(out_data) != eq || longint'(out_rem) != er || lat !== el) begin
                bad++;
                $display("FAIL random x=%h q=%0d r=%0d lat=%0d required %0d/%0d/%0d",
                         x, out_data, out_rem, lat, eq, er, el);
            end
            q0 = out_data;
            r0 = out_rem;
            hold = $urandom_range(0, 3);
            repeat (hold) @(negedge clk);
            if (hold > 0) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== q0 || out_rem !== r0) begin
                    bad++;
                    $display("FAIL random_hold v=%b q=%0d r=%0d required 1/%0d/%0d", out_valid, out_data, out_rem, q0, r0);
                end
            end
            finish_op();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        hs_cnt = 0;
        ops_cnt = 0;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_small();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        @(negedge clk);
        total++;
        if (hs_cnt !== ops_cnt) begin
            bad++;
            $display("FAIL transfer_count handshakes=%0d required %0d", hs_cnt, ops_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
